// File: rtl/hazard_detect_unit.sv
// -----------------------------------------------------------------------------
// hazard_detect_unit
//
// Decode-stage hazard unit for the 16-bit, 5-stage pipeline. It compares the
// source registers of the instruction in ID against the destination registers
// of the instructions in EX, MEM and WB. From that comparison it produces the
// operand-forwarding selects for the ID operand muxes and a load-use stall.
// All decision logic is combinational, and the block holds no state.
//
// Ports
//   clk        in   1  pipeline clock (nothing inside is clocked by it)
//   rst_n      in   1  asynchronous active-low reset; forces all outputs to 0
//   opCode     in   4  opcode of the ID instruction (instruction[15:12])
//   RS1, RS2   in   3  source register fields of the ID instruction
//   Rd2/3/4    in   3  destination registers of the EX / MEM / WB instructions
//   EX_RegWr   in   1  EX instruction writes a register
//   MEM_RegWr  in   1  MEM instruction writes a register
//   WB_RegWr   in   1  WB instruction writes a register
//   EX_MemRd   in   1  EX instruction is a load
//   stall      out  1  hold PC and IF/ID, inject a bubble into EX
//   ForwardA   out  2  operand A select: 00 regfile, 01 EX, 10 MEM, 11 WB
//   ForwardB   out  2  operand B select, same encoding
// -----------------------------------------------------------------------------
module hazard_detect_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opCode,
  input  logic [2:0] RS1,
  input  logic [2:0] RS2,
  input  logic [2:0] Rd2,
  input  logic [2:0] Rd3,
  input  logic [2:0] Rd4,
  input  logic       EX_RegWr,
  input  logic       MEM_RegWr,
  input  logic       WB_RegWr,
  input  logic       EX_MemRd,
  output logic       stall,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  // The clock exists only so that every pipeline block has the same interface.
  logic w_unused_clk;
  assign w_unused_clk = clk;

  // Pick the youngest producer. EX has priority over MEM, and MEM over WB.
  function automatic logic [1:0] fwd_sel(input logic ex, input logic mem,
                                         input logic wb);
    logic [1:0] sel;
    sel = SEL_RF;
    if (ex)       sel = SEL_EX;
    else if (mem) sel = SEL_MEM;
    else if (wb)  sel = SEL_WB;
    return sel;
  endfunction

  // Which source fields the ID instruction actually reads.
  logic w_rs1_used;
  logic w_rs2_used;

  always_comb begin
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (opCode)
      4'd0, 4'd1, 4'd2:                  begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
      4'd3, 4'd4, 4'd5, 4'd6:            begin w_rs1_used = 1'b1; end
      4'd7:                              begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
      4'd8, 4'd9, 4'd10, 4'd11:          begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
      4'd15:                             begin w_rs1_used = 1'b1; end
      default:                           begin end
    endcase
  end

  // The "used" term comes first in each match. A logical AND with a known 0
  // is 0 even when the other operand is X or Z, so a floating field that the
  // instruction does not read cannot reach the outputs.
  logic w_a_ex, w_a_mem, w_a_wb;
  logic w_b_ex, w_b_mem, w_b_wb;

  assign w_a_ex  = w_rs1_used && (RS1 != 3'd0) && (RS1 == Rd2) && EX_RegWr;
  assign w_a_mem = w_rs1_used && (RS1 != 3'd0) && (RS1 == Rd3) && MEM_RegWr;
  assign w_a_wb  = w_rs1_used && (RS1 != 3'd0) && (RS1 == Rd4) && WB_RegWr;

  assign w_b_ex  = w_rs2_used && (RS2 != 3'd0) && (RS2 == Rd2) && EX_RegWr;
  assign w_b_mem = w_rs2_used && (RS2 != 3'd0) && (RS2 == Rd3) && MEM_RegWr;
  assign w_b_wb  = w_rs2_used && (RS2 != 3'd0) && (RS2 == Rd4) && WB_RegWr;

  // A load in EX has no data yet. Stall one cycle so that the consumer can
  // take the value through the MEM forward on the next cycle.
  logic w_stall;
  assign w_stall = EX_MemRd && EX_RegWr && (w_a_ex || w_b_ex);

  // Reset gates the outputs directly, so it takes effect without a clock.
  always_comb begin
    stall    = 1'b0;
    ForwardA = SEL_RF;
    ForwardB = SEL_RF;
    if (rst_n) begin
      stall    = w_stall;
      ForwardA = fwd_sel(w_a_ex, w_a_mem, w_a_wb);
      ForwardB = fwd_sel(w_b_ex, w_b_mem, w_b_wb);
    end
  end

endmodule

// File: tb/tb_hazard_detect_unit.sv
module tb_hazard_detect_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] opCode;
  logic [2:0] RS1, RS2, Rd2, Rd3, Rd4;
  logic       EX_RegWr, MEM_RegWr, WB_RegWr, EX_MemRd;
  logic       stall;
  logic [1:0] ForwardA, ForwardB;

  hazard_detect_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opCode    (opCode),
    .RS1       (RS1),
    .RS2       (RS2),
    .Rd2       (Rd2),
    .Rd3       (Rd3),
    .Rd4       (Rd4),
    .EX_RegWr  (EX_RegWr),
    .MEM_RegWr (MEM_RegWr),
    .WB_RegWr  (WB_RegWr),
    .EX_MemRd  (EX_MemRd),
    .stall     (stall),
    .ForwardA  (ForwardA),
    .ForwardB  (ForwardB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model. Each source is treated as a request that is looked up in
  // a list of in-flight producers, ordered youngest first. The select value is
  // the position of the first producer that can satisfy the request.
  function automatic bit reads_rs1(input int op);
    return (op <= 11) || (op == 15);
  endfunction

  function automatic bit reads_rs2(input int op);
    return (op <= 2) || (op >= 7 && op <= 11);
  endfunction

  function automatic int lookup(input bit used, input int src,
                                input int rd [3], input bit wr [3]);
    if (!used || src == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (wr[i] && rd[i] == src) return i + 1;
    return 0;
  endfunction

  task automatic apply(input string name, input bit rstn, input logic [3:0] op,
                       input logic [2:0] s1, input logic [2:0] s2,
                       input int r2, input int r3, input int r4,
                       input bit exw, input bit memw, input bit wbw,
                       input bit memrd);
    exp_t e;
    int   rd [3];
    bit   wr [3];
    int   a, b;
    @(posedge clk);
    #1;
    rst_n = rstn; opCode = op; RS1 = s1; RS2 = s2;
    Rd2 = 3'(r2); Rd3 = 3'(r3); Rd4 = 3'(r4);
    EX_RegWr = exw; MEM_RegWr = memw; WB_RegWr = wbw; EX_MemRd = memrd;
    rd[0] = r2; rd[1] = r3; rd[2] = r4;
    wr[0] = exw; wr[1] = memw; wr[2] = wbw;
    a = lookup(reads_rs1(int'(op)), int'(s1), rd, wr);
    b = lookup(reads_rs2(int'(op)), int'(s2), rd, wr);
    e.name  = name;
    e.stall = rstn && memrd && (a == 1 || b == 1);
    e.fa    = rstn ? 2'(a) : 2'b00;
    e.fb    = rstn ? 2'(b) : 2'b00;
    sb.push_back(e);
  endtask

  // Monitor: outputs are combinational, so each cycle's vector is sampled
  // on the falling edge, well after the inputs were driven.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (stall !== e.stall || ForwardA !== e.fa || ForwardB !== e.fb) begin
          n_err++;
          $display("FAIL %s: got stall=%b FA=%b FB=%b, expected stall=%b FA=%b FB=%b",
                   e.name, stall, ForwardA, ForwardB, e.stall, e.fa, e.fb);
        end
      end
    end
  end

  initial begin
    int   cnt;
    logic [2:0] xs;
    rst_n = 1'b0; opCode = '0; RS1 = '0; RS2 = '0; Rd2 = '0; Rd3 = '0; Rd4 = '0;
    EX_RegWr = 0; MEM_RegWr = 0; WB_RegWr = 0; EX_MemRd = 0;

    // Reset state: a stalling pattern is masked while reset is held.
    apply("reset_hold", 0, 4'd1, 3'd5, 3'd5, 5, 5, 5, 1, 1, 1, 1);

    // ADD with forwards from EX and MEM.
    apply("add_fwd",    1, 4'd1, 3'd3, 3'd4, 3, 4, 0, 1, 1, 0, 0);
    // Load-use: stall, then the MEM forward on the next cycle.
    apply("lw_use_stall", 1, 4'd2, 3'd1, 3'd5, 5, 0, 0, 1, 0, 0, 1);
    apply("lw_use_mem",   1, 4'd2, 3'd1, 3'd5, 0, 5, 0, 0, 1, 0, 0);
    // Priority among the stages.
    apply("prio_ex",    1, 4'd0, 3'd2, 3'd0, 2, 2, 2, 1, 1, 1, 0);
    apply("prio_mem",   1, 4'd0, 3'd2, 3'd0, 6, 2, 2, 1, 1, 1, 0);
    apply("prio_wb",    1, 4'd0, 3'd2, 3'd0, 6, 7, 2, 1, 1, 1, 0);
    // R0 never matches. A stage that does not write never matches.
    apply("r0_nomatch", 1, 4'd0, 3'd0, 3'd0, 0, 0, 0, 1, 1, 1, 1);
    apply("ex_nowr",    1, 4'd0, 3'd3, 3'd0, 3, 0, 0, 0, 0, 0, 0);
    // Fields that the instruction does not read.
    apply("jmp_unused", 1, 4'd12, 3'd4, 3'd4, 4, 4, 4, 1, 1, 1, 1);
    apply("addi_rs2",   1, 4'd3, 3'd1, 3'd6, 6, 6, 6, 1, 1, 1, 0);
    apply("sw_rs2",     1, 4'd7, 3'd1, 3'd6, 0, 6, 0, 0, 1, 0, 0);
    apply("op15_rs1",   1, 4'd15, 3'd3, 3'd3, 0, 0, 3, 0, 0, 1, 0);
    // X on unused fields must not leak into the outputs.
    xs = 'x;
    apply("x_unused_jmp",  1, 4'd13, xs, xs, 2, 3, 4, 1, 1, 1, 1);
    apply("x_unused_addi", 1, 4'd4, 3'd2, xs, 2, 0, 0, 1, 0, 0, 0);
    // A stall pattern, then reset asserted in the middle of it, then released.
    apply("pre_reset_stall", 1, 4'd8, 3'd7, 3'd1, 7, 0, 0, 1, 0, 0, 1);
    apply("mid_reset",       0, 4'd8, 3'd7, 3'd1, 7, 0, 0, 1, 0, 0, 1);
    apply("post_reset",      1, 4'd8, 3'd7, 3'd1, 7, 0, 0, 1, 0, 0, 1);

    // Randomized vectors. A narrow register range makes matches frequent.
    for (int i = 0; i < 400; i++) begin
      int hi;
      hi = (i % 2 == 0) ? 3 : 7;
      apply("random", ($urandom_range(0, 31) != 0),
            4'($urandom_range(0, 15)),
            3'($urandom_range(0, hi)), 3'($urandom_range(0, hi)),
            int'($urandom_range(0, hi)), int'($urandom_range(0, hi)),
            int'($urandom_range(0, hi)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Drain the scoreboard, with a bound on the wait.
    cnt = 0;
    while (sb.size() > 0 && cnt < 20) begin
      @(posedge clk);
      cnt++;
    end
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
